// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states, held response.
// Optional DMEM_ERR_EN adds resp_err for misaligned or out-of-range addresses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept, enter_resp, resp_done, mem_we;
    logic          cur_write, cur_err;
    logic [31:0]   cur_addr, cur_wdata;
    logic [3:0]    cur_be;
    logic [AW-1:0] word_idx;

    assign accept     = req_valid & req_ready;
    assign resp_done  = (state_q == StResp) & resp_ready;
    assign enter_resp = (state_q != StResp) & (state_d == StResp);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
            StWait:  if (cnt_q == 4'd0) state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state_q == StIdle) & ~rst;
        resp_valid = (state_q == StResp);
    end

    // With zero wait states the commit happens on the accept edge, before the latch is loaded.
    always_comb begin
        if (state_q == StIdle) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign word_idx = cur_addr[AW+1:2];

`ifdef DMEM_ERR_EN
    assign cur_err  = (cur_addr[1:0] != 2'b00) || (cur_addr >= 32'(DEPTH_WORDS * 4));
    assign resp_err = err_q;
`else
    logic unused_addr;
    assign cur_err     = 1'b0;
    assign unused_addr = ^{cur_addr[31:AW+2], cur_addr[1:0], err_q};
`endif

    always_comb begin
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            if (WAIT_CYCLES != 0) cnt_d = 4'(WAIT_CYCLES - 1);
        end else if (state_q == StWait && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (enter_resp) begin
            rdata_d = (cur_write || cur_err) ? 32'd0 : mem_q[word_idx];
            err_d   = cur_err;
        end else if (resp_done) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A reset landing on the commit edge abandons the write.
    assign mem_we = enter_resp & cur_write & ~cur_err & ~rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem_q[word_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances share one stimulus.
// Build with +define+DMEM_ERR_EN to exercise the error-response variant.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready2, resp_valid2, req_ready0, resp_valid0;
    logic [31:0] resp_rdata2, resp_rdata0;
`ifdef DMEM_ERR_EN
    logic        resp_err2, resp_err0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready2),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid2),
        .resp_ready (resp_ready),
`ifdef DMEM_ERR_EN
        .resp_err   (resp_err2),
`endif
        .resp_rdata (resp_rdata2)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready0),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid0),
        .resp_ready (resp_ready),
`ifdef DMEM_ERR_EN
        .resp_err   (resp_err0),
`endif
        .resp_rdata (resp_rdata0)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called and returns at a falling edge; one complete transaction on both instances.
    task automatic txn(input string nm, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] e2, input logic [31:0] e0, input logic err);
        int l2, l0;
        check({nm, "/ready2"}, 32'(req_ready2), 32'd1);
        check({nm, "/ready0"}, 32'(req_ready0), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        l2 = -1;
        l0 = -1;
        for (int c = 1; c <= 20 && (l2 < 0 || l0 < 0); c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Latched request must ignore these
                req_valid = 1'b0;
                req_write = ~w;
                req_addr  = a ^ 32'h4;
                req_wdata = ~wd;
                req_be    = ~be;
            end
            if (l0 < 0 && resp_valid0) l0 = c;
            if (l2 < 0 && resp_valid2) l2 = c;
            check({nm, "/busy2"}, 32'(req_ready2), 32'd0);
        end
        check({nm, "/lat2"}, 32'(l2), 32'd3);
        check({nm, "/lat0"}, 32'(l0), 32'd1);
        check({nm, "/rdata2"}, resp_rdata2, e2);
        check({nm, "/rdata0"}, resp_rdata0, e0);
`ifdef DMEM_ERR_EN
        check({nm, "/err2"}, 32'(resp_err2), 32'(err));
        check({nm, "/err0"}, 32'(resp_err0), 32'(err));
`else
        if (err) $display("note: %s expects an error only with DMEM_ERR_EN", nm);
`endif
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({nm, "/done_v2"}, 32'(resp_valid2), 32'd0);
        check({nm, "/done_v0"}, 32'(resp_valid0), 32'd0);
        check({nm, "/done_rd2"}, resp_rdata2, 32'd0);
        check({nm, "/done_rdy2"}, 32'(req_ready2), 32'd1);
        check({nm, "/done_rdy0"}, 32'(req_ready0), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 32'h0,   32'h01020304, 4'hF, 32'h0, 1'b0};
`ifdef DMEM_ERR_EN
        vecs[8]  = '{1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h01020304, 1'b0};
        vecs[10] = '{1'b0, 32'h2,   32'h0,        4'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 32'h13,  32'h0,        4'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 32'hFFFFF010, 32'h0,   4'h0, 32'h0, 1'b1};
`else
        vecs[8]  = '{1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b0, 32'h2,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b0, 32'h13,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFFF010, 32'h0,   4'h0, 32'hDEADBEEF, 1'b0};
`endif

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_be     = 4'h0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/ready2", 32'(req_ready2), 32'd0);
        check("rst/ready0", 32'(req_ready0), 32'd0);
        rst = 1'b0;
        #1;
        check("rst/valid2", 32'(resp_valid2), 32'd0);
        check("rst/rdata2", resp_rdata2, 32'd0);
        check("rst/valid0", 32'(resp_valid0), 32'd0);

        for (int i = 0; i < 13; i++) begin
            txn($sformatf("v%0d", i), vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].be,
                vecs[i].exp, vecs[i].exp, vecs[i].err);
        end

        // Backpressure: held response, no second accept while req_valid stays high
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        begin
            int k;
            k = 0;
            while (!resp_valid2 && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("bp/arrive", 32'(resp_valid2), 32'd1);
        end
        for (int c = 0; c < 5; c++) begin
            check("bp/valid2", 32'(resp_valid2), 32'd1);
            check("bp/rdata2", resp_rdata2, 32'hDEADBEEF);
            check("bp/ready2", 32'(req_ready2), 32'd0);
            check("bp/valid0", 32'(resp_valid0), 32'd1);
            check("bp/rdata0", resp_rdata0, 32'hDEADBEEF);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp/idle_rdy2", 32'(req_ready2), 32'd1);
        check("bp/idle_v2", 32'(resp_valid2), 32'd0);

        // Reset during WAIT: the slow instance never commits, the zero-wait one already did
        txn("pre20", 1'b1, 32'h20, 32'hAAAA5555, 4'hF, 32'h0, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        check("mrst/busy2", 32'(req_ready2), 32'd0);
        rst = 1'b1;
        #1;
        check("mrst/ready_in_rst", 32'(req_ready2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst/ready2", 32'(req_ready2), 32'd1);
        check("mrst/ready0", 32'(req_ready0), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mrst/novalid2", 32'(resp_valid2), 32'd0);
        end
        txn("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'hAAAA5555, 32'h12345678, 1'b0);

        // Zero-wait back-to-back with resp_ready tied high
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("b2b/ready0", 32'(req_ready0), 32'(c % 2 == 0));
            check("b2b/valid0", 32'(resp_valid0), 32'(c % 2 == 1));
            if (c % 2 == 1) check("b2b/rdata0", resp_rdata0, 32'hDEADBEEF);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        resp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
